// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ requesters.
// Each grant captures a word, pulses tx start, and waits for done or a watchdog abort.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 10,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   data_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          done_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] owner_o,
  output logic [DATA_W-1:0]         tx_din_o,
  output logic                      tx_start_o,
  input  logic                      tx_done_tick_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                start_q, start_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [DATA_W-1:0]   words [N_REQ];
  logic                found;
  logic [IDX_W-1:0]    pick;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign words[g] = data_i[g*DATA_W +: DATA_W];
  end

  // Scan from the slot after the last winner, wrapping, so the last winner ranks lowest.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(last_q) + 32'd1 + i) % N_REQ;
      if (!found && req_i[IDX_W'(idx)]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    start_d = 1'b0;
    busy_d  = busy_q;
    owner_d = owner_q;
    last_d  = last_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (found) begin
          din_d       = words[pick];
          start_d     = 1'b1;
          gnt_d[pick] = 1'b1;
          owner_d     = pick;
          last_d      = pick;
          busy_d      = 1'b1;
          cnt_d       = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A done tick on the final watchdog cycle still counts as a completion.
        if (tx_done_tick_i) begin
          done_d[owner_q] = 1'b1;
          busy_d          = 1'b0;
          state_d         = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      owner_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      din_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign busy_o     = busy_q;
  assign owner_o    = owner_q;
  assign tx_din_o   = din_q;
  assign tx_start_o = start_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed table, corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 10;
  localparam int T = 40;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic           tick;
  logic [N-1:0]   gnt_o, done_o;
  logic           err_o, busy_o, tx_start_o;
  logic [1:0]     owner_o;
  logic [W-1:0]   tx_din_o;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(T)) dut (
    .clk            (clk),
    .rst_n_i        (rst_n),
    .req_i          (req),
    .data_i         (data),
    .gnt_o          (gnt_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .busy_o         (busy_o),
    .owner_o        (owner_o),
    .tx_din_o       (tx_din_o),
    .tx_start_o     (tx_start_o),
    .tx_done_tick_i (tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic set_data(input int k, input logic [W-1:0] w);
    for (int j = 0; j < N; j++) data[j*W +: W] = (j == k) ? w : ~w;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [W-1:0] word;
    logic [N-1:0] gnt;
    int           owner;
  } vec_t;

  vec_t tbl[8];

  // Reference model: frame ownership, watchdog count and round-robin pointer.
  logic [N-1:0] exp_gnt, exp_done;
  logic         exp_err, exp_start, exp_busy;
  int           exp_owner, m_last, m_cnt;
  logic [W-1:0] exp_din;

  task automatic model_reset();
    exp_gnt = '0; exp_done = '0; exp_err = 0; exp_start = 0; exp_busy = 0;
    exp_owner = 0; exp_din = '0; m_last = N - 1; m_cnt = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic t);
    exp_gnt = '0; exp_done = '0; exp_err = 0; exp_start = 0;
    if (!exp_busy) begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (m_last + i) % N;
        if (r[k]) begin
          exp_gnt[k] = 1'b1; exp_start = 1'b1; exp_owner = k;
          exp_din = d[k*W +: W]; m_last = k; m_cnt = 0; exp_busy = 1'b1;
          break;
        end
      end
    end else if (t) begin
      exp_done[exp_owner] = 1'b1; exp_busy = 1'b0;
    end else if (m_cnt == T - 1) begin
      exp_err = 1'b1; exp_busy = 1'b0;
    end else begin
      m_cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int lat;
    bit seen_err, seen_done;
    int cyc, pend, sel;

    tbl[0] = '{4'b0001, 10'h2A5, 4'b0001, 0};
    tbl[1] = '{4'b1111, 10'h133, 4'b0010, 1};
    tbl[2] = '{4'b1111, 10'h0F0, 4'b0100, 2};
    tbl[3] = '{4'b0101, 10'h3C3, 4'b0001, 0};
    tbl[4] = '{4'b0101, 10'h055, 4'b0100, 2};
    tbl[5] = '{4'b1000, 10'h1FF, 4'b1000, 3};
    tbl[6] = '{4'b1111, 10'h200, 4'b0001, 0};
    tbl[7] = '{4'b0010, 10'h001, 4'b0010, 1};

    rst_n = 1'b0; req = '0; data = '0; tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {gnt_o, done_o, err_o, busy_o, owner_o, tx_din_o, tx_start_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arbitration table, one full frame per record.
    for (int v = 0; v < 8; v++) begin
      req = tbl[v].req;
      set_data(tbl[v].owner, tbl[v].word);
      @(negedge clk);
      chk("tbl_gnt", gnt_o, tbl[v].gnt);
      chk("tbl_start", tx_start_o, 1);
      chk("tbl_owner", owner_o, tbl[v].owner);
      chk("tbl_din", tx_din_o, tbl[v].word);
      chk("tbl_busy", busy_o, 1);
      req = '0;
      @(negedge clk);
      chk("tbl_pulse_end", {gnt_o, tx_start_o}, 0);
      chk("tbl_din_hold", tx_din_o, tbl[v].word);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk("tbl_done", done_o, tbl[v].gnt);
      chk("tbl_busy_low", busy_o, 0);
      @(negedge clk);
      chk("tbl_done_width", done_o, 0);
    end

    // Watchdog: no done tick, err exactly T cycles after the start cycle.
    req = 4'b0001; set_data(0, 10'h0AA);
    @(negedge clk);
    chk("to_start", {gnt_o, tx_start_o}, {4'b0001, 1'b1});
    req = '0;
    lat = 0; seen_err = 0; seen_done = 0;
    for (int i = 1; i <= T + 5 && !seen_err; i++) begin
      @(negedge clk);
      if (done_o != 0) seen_done = 1;
      if (err_o) begin seen_err = 1; lat = i; end
    end
    chk("to_latency", lat, T);
    chk("to_no_done", seen_done, 0);
    @(negedge clk);
    chk("to_err_width", err_o, 0);
    chk("to_busy_low", busy_o, 0);
    req = 4'b0100; set_data(2, 10'h321);
    @(negedge clk);
    chk("to_next_gnt", gnt_o, 4'b0100);
    chk("to_next_din", tx_din_o, 10'h321);
    req = '0; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("to_next_done", done_o, 4'b0100);

    // Done tick on the final watchdog cycle wins over the abort.
    req = 4'b0001; set_data(0, 10'h155);
    @(negedge clk);
    chk("edge_gnt", gnt_o, 4'b0001);
    req = '0;
    repeat (T - 1) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("edge_done", done_o, 4'b0001);
    chk("edge_no_err", err_o, 0);
    @(negedge clk);
    chk("edge_no_err_late", err_o, 0);

    // Reset in the middle of a frame, then a stale done tick.
    req = 4'b1000; set_data(3, 10'h3E7);
    @(negedge clk);
    chk("rst_pre_gnt", gnt_o, 4'b1000);
    req = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_zero", {gnt_o, done_o, err_o, busy_o, owner_o, tx_din_o, tx_start_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("rst_stale_done", done_o, 0);
    chk("rst_stale_busy", busy_o, 0);
    req = 4'b1111; set_data(0, 10'h0F1);
    @(negedge clk);
    chk("rst_prio_gnt", gnt_o, 4'b0001);
    req = '0; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("rst_prio_done", done_o, 4'b0001);

    // Randomized traffic against the reference model.
    @(negedge clk);
    rst_n = 1'b0; req = '0; tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    pend = -1;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("rnd_gnt", gnt_o, exp_gnt);
      chk("rnd_done", done_o, exp_done);
      chk("rnd_err", err_o, exp_err);
      chk("rnd_busy", busy_o, exp_busy);
      chk("rnd_start", tx_start_o, exp_start);
      chk("rnd_owner", owner_o, exp_owner);
      chk("rnd_din", tx_din_o, exp_din);
      for (int k = 0; k < N; k++) begin
        if (exp_gnt[k] && ($urandom % 2 == 0)) req[k] = 1'b0;
        else if (!req[k] && ($urandom % 4 == 0)) begin
          data[k*W +: W] = W'($urandom);
          req[k] = 1'b1;
        end
      end
      if (exp_start) begin
        sel = $urandom % 8;
        if (sel == 0)      pend = -1;
        else if (sel == 1) pend = cyc + T - 1;
        else if (sel == 2) pend = cyc + T;
        else               pend = cyc + 1 + int'($urandom % 12);
      end
      if (pend == cyc)                           tick = 1'b1;
      else if (!exp_busy && ($urandom % 16 == 0)) tick = 1'b1;
      else                                       tick = 1'b0;
      model_step(req, data, tick);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
